fifo_rd_drainer: RTL

Read-side consumer engine for the team's asynchronous FIFO. It runs entirely in the read-clock domain and drains the FIFO read port (r_data / r_empty / destination_r_en) into a 2-entry skid buffer. The buffer feeds a valid/ready downstream stream. An in-line sequence checker flags lost or duplicated words in incrementing test traffic, which moves the bench's data-loss check into synthesizable RTL.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/rd_skid_buffer.sv | 70 +++++++
 rtl/fifo_rd_drainer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side drainer.
//   - Default geometry constants used by both sides of the FIFO.
//   - Drainer FSM state encoding.
//   - Skid buffer depth used for pop gating.
package fifo_pkg;

  // Default FIFO geometry; the drainer data width must match the FIFO WIDTH.
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_PTR_WIDTH = $clog2(DEF_DEPTH);

  // Drainer FSM encoding (values are shared with the FIFO status decoding).
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } drain_state_t;

  // Number of entries in the read-side skid buffer.
  localparam logic [1:0] SKID_DEPTH = 2'd2;

endpackage

// File: rtl/rd_skid_buffer.sv
// Two-entry in-order skid buffer between the FIFO read port and the
// downstream valid/ready stream.
//   r_clk      : clock
//   reset      : asynchronous active-low reset, empties the buffer
//   push       : write push_data this edge (ignored when full)
//   push_data  : word to store
//   pop        : remove the oldest entry this edge (ignored when empty)
//   head_data  : oldest entry, held stable until popped
//   occupancy  : number of stored entries, 0..2
module rd_skid_buffer
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             r_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy
);

  // slot0 is always the oldest entry; slot1 is only meaningful at occupancy 2.
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       occ;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (occ != SKID_DEPTH);
  assign pop_ok  = pop  && (occ != 2'd0);

  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      occ   <= 2'd0;
      // NOTE: the two data slots are reset (cheap at this size) so head_data,
      // and therefore the block's out_data, reads 0 while in reset; a larger
      // storage array would normally be left unreset.
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (occ == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy unchanged, order kept.
          if (occ == SKID_DEPTH) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = slot0;
  assign occupancy = occ;

endmodule

// File: rtl/fifo_rd_drainer.sv
// Read-side consumer engine for the asynchronous FIFO (read-clock domain).
// Pops first-word-fall-through FIFO data into a 2-entry skid buffer that
// feeds a valid/ready stream, and checks that the popped words form an
// incrementing sequence.
//   r_clk, reset       : clock, asynchronous active-low reset
//   enable             : run request (IDLE/RUN/STOPPING FSM)
//   err_clr            : synchronous clear of err_count / err_sticky
//   r_data, r_empty    : FIFO head word and empty flag
//   destination_r_en   : FIFO pop strobe
//   out_data/valid/ready : downstream stream
//   seq_err            : one-cycle pulse after a mismatching pop
//   err_sticky         : any mismatch since last clear
//   err_count          : saturating mismatch count
//   words_read         : wrapping pop count
//   busy               : FSM not in IDLE
module fifo_rd_drainer
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned SEQ_START = 1,
  parameter bit          CHECK_EN  = 1'b1
) (
  input  logic                 r_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 err_clr,
  input  logic [WIDTH-1:0]     r_data,
  input  logic                 r_empty,
  output logic                 destination_r_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 seq_err,
  output logic                 err_sticky,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] words_read,
  output logic                 busy
);

  drain_state_t     state_q;
  drain_state_t     state_d;
  logic [1:0]       occupancy;
  logic             pop;
  logic             xfer;
  logic             mismatch;
  logic [WIDTH-1:0] expected;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // process triggered by this edge still sees the pre-edge value.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enable) state_d = RUN;
      RUN:      if (!enable) state_d = STOPPING;
      STOPPING: begin
        if (enable)                  state_d = RUN;
        else if (occupancy == 2'd0)  state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Pop gating and skid buffer. The pop depends only on registered state,
  // registered occupancy and r_empty, never on out_ready, so the FIFO
  // read port has no combinational path from downstream.
  // ---------------------------------------------------------------------
  assign pop              = (state_q == RUN) && !r_empty && (occupancy < SKID_DEPTH);
  assign destination_r_en = pop;
  assign xfer             = out_valid && out_ready;
  assign out_valid        = (occupancy != 2'd0);

  rd_skid_buffer #(
    .WIDTH (WIDTH)
  ) u_skid (
    .r_clk     (r_clk),
    .reset     (reset),
    .push      (pop),
    .push_data (r_data),
    .pop       (xfer),
    .head_data (out_data),
    .occupancy (occupancy)
  );

  // ---------------------------------------------------------------------
  // Word counter and sequence checker
  // ---------------------------------------------------------------------
  assign mismatch = CHECK_EN && pop && (r_data != expected);

  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      words_read <= '0;
      expected   <= WIDTH'(SEQ_START);
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      seq_err <= mismatch;
      if (pop) begin
        words_read <= words_read + CNT_WIDTH'(1);
        // Resync on every pop so one lost word costs exactly one error;
        // the natural wrap of the addition makes max -> 0 legal.
        expected   <= r_data + WIDTH'(1);
      end
      // A mismatch in the same cycle as err_clr takes precedence.
      if (mismatch) begin
        err_sticky <= 1'b1;
        if (err_clr)          err_count <= CNT_WIDTH'(1);
        else if (!(&err_count)) err_count <= err_count + CNT_WIDTH'(1);
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end

endmodule
